// File: rtl/bls12_381_data_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// bls12_381_data_ram_arbiter_if
//
// Request/response bundle for one data-RAM requester (instruction core or
// host AXI-lite bridge).
//
// Signals:
//   req   requester -> arbiter   request valid, held until gnt
//   we    requester -> arbiter   1 = write, 0 = read
//   a     requester -> arbiter   RAM word address
//   d     requester -> arbiter   RAM write data
//   gnt   arbiter -> requester   request accepted this cycle (combinational)
//   q     arbiter -> requester   read data returned to this requester
//   qval  arbiter -> requester   q valid, one cycle per read
//
// Modports:
//   master  the requester side
//   slave   the arbiter side
// ---------------------------------------------------------------------------
interface bls12_381_data_ram_arbiter_if #(
    parameter int DAT_BITS = 384,
    parameter int ADR_BITS = 14
);
    logic                req;
    logic                we;
    logic [ADR_BITS-1:0] a;
    logic [DAT_BITS-1:0] d;
    logic                gnt;
    logic [DAT_BITS-1:0] q;
    logic                qval;

    modport master (output req, we, a, d, input gnt, q, qval);
    modport slave  (input req, we, a, d, output gnt, q, qval);
endinterface

// File: rtl/bls12_381_data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// bls12_381_data_ram_arbiter
//
// Shares the single data-RAM port of the bls12-381 coprocessor between the
// instruction core and the host bridge. Core requests win, except that a
// host denied for MAX_STALL consecutive cycles is granted by force. One
// registered RAM command is issued per cycle. A shift register of
// {valid, owner} tracks each read through the RAM latency so that the
// returning word reaches only the requester that issued it.
//
// Ports:
//   i_clk           clock
//   i_rst           synchronous active-high reset
//   i_hold          suppresses all grants (RAM reset in progress)
//   core            core requester port (slave side)
//   host            host requester port (slave side)
//   o_ram_en        registered RAM enable
//   o_ram_re        registered RAM read strobe
//   o_ram_we        registered RAM write strobe
//   o_ram_a         registered RAM address (holds when idle)
//   o_ram_d         registered RAM write data (holds when idle)
//   i_ram_q         RAM read data, valid READ_CYCLE cycles after a command
//   o_host_starved  high in a cycle where the host grant is forced
//
// READ_CYCLE must be at least 1.
// ---------------------------------------------------------------------------
module bls12_381_data_ram_arbiter #(
    parameter int DAT_BITS   = 384,
    parameter int ADR_BITS   = 14,
    parameter int READ_CYCLE = 3,
    parameter int MAX_STALL  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_hold,
    bls12_381_data_ram_arbiter_if.slave   core,
    bls12_381_data_ram_arbiter_if.slave   host,
    output logic                          o_ram_en,
    output logic                          o_ram_re,
    output logic                          o_ram_we,
    output logic [ADR_BITS-1:0]           o_ram_a,
    output logic [DAT_BITS-1:0]           o_ram_d,
    input  logic [DAT_BITS-1:0]           i_ram_q,
    output logic                          o_host_starved
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    logic [SW-1:0]         stall_cnt;
    logic                  core_gnt;
    logic                  host_gnt;
    logic                  forced;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADR_BITS-1:0]   sel_a;
    logic [DAT_BITS-1:0]   sel_d;
    logic                  rd_gnt;

    // Owner pipeline: stage k is valid during cycle T+1+k for a read granted
    // at edge T; pipe_own is 1 when the host owns the read.
    logic [READ_CYCLE:0]   pipe_val;
    logic [READ_CYCLE:0]   pipe_own;
    logic                  fin_core;
    logic                  fin_host;
    logic [DAT_BITS-1:0]   core_q_r;
    logic [DAT_BITS-1:0]   host_q_r;

    // Grants are gated by reset as well so nothing is accepted while the
    // pipeline and command registers are being cleared.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        forced   = 1'b0;
        if (!i_rst && !i_hold) begin
            if (stall_cnt == STALL_MAX && host.req) begin
                host_gnt = 1'b1;
                forced   = 1'b1;
            end else if (core.req) begin
                core_gnt = 1'b1;
            end else if (host.req) begin
                host_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = core_gnt | host_gnt;
    assign sel_we  = core_gnt ? core.we : host.we;
    assign sel_a   = core_gnt ? core.a  : host.a;
    assign sel_d   = core_gnt ? core.d  : host.d;
    assign rd_gnt  = any_gnt & ~sel_we;

    // Consecutive denied host-request cycles; frozen while i_hold is high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (i_hold) begin
            stall_cnt <= stall_cnt;
        end else if (!host.req || host_gnt) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Registered RAM command; address and data hold when no grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ram_en <= 1'b0;
            o_ram_re <= 1'b0;
            o_ram_we <= 1'b0;
            o_ram_a  <= '0;
            o_ram_d  <= '0;
        end else begin
            o_ram_en <= any_gnt;
            o_ram_re <= any_gnt & ~sel_we;
            o_ram_we <= any_gnt & sel_we;
            if (any_gnt) begin
                o_ram_a <= sel_a;
                o_ram_d <= sel_d;
            end
        end
    end

    // The pipeline keeps shifting under i_hold so in-flight reads complete.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_val <= '0;
            pipe_own <= '0;
        end else begin
            pipe_val <= {pipe_val[READ_CYCLE-1:0], rd_gnt};
            pipe_own <= {pipe_own[READ_CYCLE-1:0], host_gnt};
        end
    end

    assign fin_core = pipe_val[READ_CYCLE] & ~pipe_own[READ_CYCLE];
    assign fin_host = pipe_val[READ_CYCLE] &  pipe_own[READ_CYCLE];

    // The RAM word is only present during the final-stage cycle, so it is
    // passed through then and latched here to keep q stable afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            core_q_r <= '0;
            host_q_r <= '0;
        end else begin
            if (fin_core) core_q_r <= i_ram_q;
            if (fin_host) host_q_r <= i_ram_q;
        end
    end

    assign core.gnt       = core_gnt;
    assign host.gnt       = host_gnt;
    assign core.qval      = fin_core;
    assign host.qval      = fin_host;
    assign core.q         = fin_core ? i_ram_q : core_q_r;
    assign host.q         = fin_host ? i_ram_q : host_q_r;
    assign o_host_starved = forced;

endmodule

// File: tb/tb_bls12_381_data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bls12_381_data_ram_arbiter
//
// Directed bench for bls12_381_data_ram_arbiter with MAX_STALL=4 and
// READ_CYCLE=3, driving both requester interfaces and modelling the data
// RAM (preloaded pattern, 3-cycle read latency).
// ---------------------------------------------------------------------------
module tb_bls12_381_data_ram_arbiter;

    localparam int DAT_BITS   = 384;
    localparam int ADR_BITS   = 14;
    localparam int READ_CYCLE = 3;
    localparam int MAX_STALL  = 4;

    logic                clk;
    logic                rst;
    logic                hold;
    logic                ram_en;
    logic                ram_re;
    logic                ram_we;
    logic [ADR_BITS-1:0] ram_a;
    logic [DAT_BITS-1:0] ram_d;
    logic [DAT_BITS-1:0] ram_q;
    logic                starved;

    int checks = 0;
    int errors = 0;

    bls12_381_data_ram_arbiter_if #(.DAT_BITS(DAT_BITS), .ADR_BITS(ADR_BITS)) core_if ();
    bls12_381_data_ram_arbiter_if #(.DAT_BITS(DAT_BITS), .ADR_BITS(ADR_BITS)) host_if ();

    bls12_381_data_ram_arbiter #(
        .DAT_BITS   (DAT_BITS),
        .ADR_BITS   (ADR_BITS),
        .READ_CYCLE (READ_CYCLE),
        .MAX_STALL  (MAX_STALL)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hold         (hold),
        .core           (core_if),
        .host           (host_if),
        .o_ram_en       (ram_en),
        .o_ram_re       (ram_re),
        .o_ram_we       (ram_we),
        .o_ram_a        (ram_a),
        .o_ram_d        (ram_d),
        .i_ram_q        (ram_q),
        .o_host_starved (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preload contents of the modelled RAM.
    function automatic logic [DAT_BITS-1:0] pattern(input int i);
        if (i == 5) return 384'hABC;
        return {8'(i), 360'h0, 16'hBEEF};
    endfunction

    // RAM model: three register stages from command to read data.
    logic [DAT_BITS-1:0] mem [0:63];
    logic [DAT_BITS-1:0] rq0, rq1, rq2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= pattern(i);
        end else if (ram_en && ram_we) begin
            mem[ram_a[5:0]] <= ram_d;
        end
        rq0 <= mem[ram_a[5:0]];
        rq1 <= rq0;
        rq2 <= rq1;
    end

    assign ram_q = rq2;

    task automatic applyStimulus(
        input logic creq, input logic cwe, input int ca, input logic [DAT_BITS-1:0] cd,
        input logic hreq, input logic hwe, input int ha, input logic [DAT_BITS-1:0] hd);
        core_if.req = creq;
        core_if.we  = cwe;
        core_if.a   = ADR_BITS'(ca);
        core_if.d   = cd;
        host_if.req = hreq;
        host_if.we  = hwe;
        host_if.a   = ADR_BITS'(ha);
        host_if.d   = hd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DAT_BITS-1:0] obs,
                               input logic [DAT_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [DAT_BITS-1:0] WDATA = {16'h1234, 352'h0, 16'h5678};

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_ram_en", ram_en, 0);
        checkOutput("rst_core_gnt", core_if.gnt, 0);
        checkOutput("rst_host_qval", host_if.qval, 0);
        checkOutput("rst_starved", starved, 0);
        checkOutput("rst_stall_cnt", dut.stall_cnt, 0);
        nextCycle();
        rst = 1'b0;

        // Single host read of 0x5
        $display("[TB] single host read");
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 5, '0);
        @(negedge clk);
        checkOutput("hr_host_gnt", host_if.gnt, 1);
        checkOutput("hr_core_gnt", core_if.gnt, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("hr_ram_en", ram_en, 1);
        checkOutput("hr_ram_re", ram_re, 1);
        checkOutput("hr_ram_we", ram_we, 0);
        checkOutput("hr_ram_a", ram_a, 5);
        nextCycle();
        @(negedge clk);
        checkOutput("hr_qval_early2", host_if.qval, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("hr_qval_early3", host_if.qval, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("hr_host_qval", host_if.qval, 1);
        checkOutput("hr_host_q", host_if.q, 384'hABC);
        checkOutput("hr_core_qval", core_if.qval, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("hr_qval_after", host_if.qval, 0);
        checkOutput("hr_q_hold", host_if.q, 384'hABC);

        // Simultaneous requests
        $display("[TB] simultaneous requests");
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1, '0, 1'b1, 1'b0, 2, '0);
        @(negedge clk);
        checkOutput("sim_core_gnt", core_if.gnt, 1);
        checkOutput("sim_host_gnt", host_if.gnt, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 2, '0);
        @(negedge clk);
        checkOutput("sim_stall1", dut.stall_cnt, 1);
        checkOutput("sim_host_gnt2", host_if.gnt, 1);
        checkOutput("sim_core_gnt2", core_if.gnt, 0);
        checkOutput("sim_starved", starved, 0);
        checkOutput("sim_ram_a1", ram_a, 1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("sim_ram_a2", ram_a, 2);
        checkOutput("sim_stall0", dut.stall_cnt, 0);
        repeat (5) nextCycle();

        // Starvation under continuous core load
        $display("[TB] host starvation");
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 3, '0, 1'b1, 1'b0, 4, '0);
            @(negedge clk);
            checkOutput($sformatf("stv_core_gnt%0d", i), core_if.gnt, (i < 4) ? 1 : 0);
            checkOutput($sformatf("stv_host_gnt%0d", i), host_if.gnt, (i == 4) ? 1 : 0);
            checkOutput($sformatf("stv_starved%0d", i), starved, (i == 4) ? 1 : 0);
        end
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("stv_stall_clr", dut.stall_cnt, 0);
        checkOutput("stv_ram_a", ram_a, 4);
        checkOutput("stv_starved_low", starved, 0);
        repeat (6) nextCycle();

        // Alternating core/host reads
        $display("[TB] alternating reads");
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            if (i % 2 == 0) applyStimulus(1'b1, 1'b0, i + 1, '0, 1'b0, 1'b0, 0, '0);
            else            applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, i + 1, '0);
            @(negedge clk);
            checkOutput($sformatf("alt_gnt%0d", i),
                        (i % 2 == 0) ? core_if.gnt : host_if.gnt, 1);
        end
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            idle();
            @(negedge clk);
            checkOutput($sformatf("alt_core_qval%0d", i), core_if.qval, (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("alt_host_qval%0d", i), host_if.qval, (i % 2 == 1) ? 1 : 0);
            checkOutput($sformatf("alt_q%0d", i),
                        (i % 2 == 0) ? core_if.q : host_if.q, pattern(i + 1));
        end

        // Write followed by read of the same address
        $display("[TB] write then read");
        nextCycle();
        applyStimulus(1'b1, 1'b1, 6, WDATA, 1'b0, 1'b0, 0, '0);
        @(negedge clk);
        checkOutput("wr_core_gnt", core_if.gnt, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 6, '0);
        @(negedge clk);
        checkOutput("wr_host_gnt", host_if.gnt, 1);
        checkOutput("wr_ram_we", ram_we, 1);
        checkOutput("wr_ram_re", ram_re, 0);
        checkOutput("wr_ram_d", ram_d, WDATA);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("wr_core_qval", core_if.qval, 0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("wr_host_qval", host_if.qval, 1);
        checkOutput("wr_host_q", host_if.q, WDATA);
        repeat (3) nextCycle();

        // Hold with both requesting, one read already in flight
        $display("[TB] hold");
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1, '0, 1'b1, 1'b0, 2, '0);
        @(negedge clk);
        checkOutput("hld_pre_core_gnt", core_if.gnt, 1);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            hold = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("hld_core_gnt%0d", i), core_if.gnt, 0);
            checkOutput($sformatf("hld_host_gnt%0d", i), host_if.gnt, 0);
            checkOutput($sformatf("hld_stall%0d", i), dut.stall_cnt, 1);
            if (i > 0) checkOutput($sformatf("hld_ram_en%0d", i), ram_en, 0);
            checkOutput($sformatf("hld_core_qval%0d", i), core_if.qval, (i == 3) ? 1 : 0);
            if (i == 3) checkOutput("hld_core_q", core_if.q, pattern(1));
        end
        nextCycle();
        hold = 1'b0;
        @(negedge clk);
        checkOutput("hld_resume_core", core_if.gnt, 1);
        checkOutput("hld_resume_host", host_if.gnt, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 2, '0);
        @(negedge clk);
        checkOutput("hld_stall2", dut.stall_cnt, 2);
        checkOutput("hld_host_gnt", host_if.gnt, 1);
        nextCycle();
        idle();
        repeat (6) nextCycle();

        // Reset with a core read in flight
        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b0, 3, '0, 1'b0, 1'b0, 0, '0);
        @(negedge clk);
        checkOutput("mr_core_gnt", core_if.gnt, 1);
        nextCycle();
        idle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mr_ram_en_pre", ram_en, 1);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mr_ram_en", ram_en, 0);
        checkOutput("mr_ram_re", ram_re, 0);
        checkOutput("mr_ram_we", ram_we, 0);
        checkOutput("mr_ram_a", ram_a, 0);
        checkOutput("mr_ram_d", ram_d, 0);
        checkOutput("mr_core_q", core_if.q, 0);
        checkOutput("mr_host_q", host_if.q, 0);
        checkOutput("mr_core_qval", core_if.qval, 0);
        checkOutput("mr_host_qval", host_if.qval, 0);
        checkOutput("mr_starved", starved, 0);
        checkOutput("mr_gnts", {core_if.gnt, host_if.gnt}, 0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("mr_no_qval%0d", i), core_if.qval, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
